fpu_final_phase_ctrl: RTL and testbench
=======================================

Name: fpu_final_phase_ctrl

Overview:
- FSM controller that sequences the final phases of the floating-point multiplier datapath: rounding, post-round significand normalization, exponent correction, exception flag capture and output packing.
- It drives the register loads of the post-round normalization stage, which outputs the 23/52-bit significand plus the exp_na flag. It consumes exp_na to decide whether an exponent-increment phase is needed.
- It handshakes with the upstream operation sequencer (beg_op) and the downstream consumer (ready/ack_op).

Parameters:
- W_Sgf, 23, significand width; 23 = single, 52 = double. Carried for consistency only; no datapath in this block.
- RND_LAT, 1, wait cycles after rounding load before normalization may load; 0..15; 0 skips the wait state.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- beg_op  in  1  start request; sampled only in IDLE.
- ack_op  in  1  consumer acknowledge of result; sampled only in DONE.
- exp_na  in  1  registered exponent-actualization flag from the normalization stage.
- overflow_flag  in  1  exponent overflow from the exponent unit.
- underflow_flag  in  1  exponent underflow from the exponent unit.
- load_rnd  out  1  load strobe, rounding register.
- load_norm  out  1  load strobe, normalization stage registers (significand and exp_na).
- load_exp  out  1  load strobe, exponent register.
- sel_exp_inc  out  1  selects +1 operand on the exponent adder.
- load_flags  out  1  load strobe, exception flag register.
- load_final  out  1  load strobe, packed IEEE result register.
- exc_sel  out  2  output mux select: 00 normal, 01 overflow→inf, 10 underflow→zero, 11 unused.
- busy  out  1  high in every state except IDLE.
- ready  out  1  result valid; high only in DONE.

Behaviour:
- Reset (rst==0 at clk edge):
  - State goes to IDLE; latency counter is cleared.
  - All outputs are 0 from the next cycle, including when reset arrives mid-operation.
- Outputs are Moore, decoded from the state register. Each load strobe is exactly one cycle wide.
- States and transitions:
  - IDLE: no strobes. beg_op=1 → ROUND.
  - ROUND: load_rnd=1. If RND_LAT=0 → NORM; otherwise load counter with RND_LAT → RWAIT.
  - RWAIT: counter decrements each cycle. Leave when counter==1 → NORM. The state occupies exactly RND_LAT cycles.
  - NORM: load_norm=1 → NA_CHK.
  - NA_CHK: exp_na (now valid from the normalization register) is sampled. 1 → EXP_UPD; 0 → FLAGS.
  - EXP_UPD: load_exp=1 and sel_exp_inc=1 → FLAGS.
  - FLAGS: load_flags=1. overflow_flag and underflow_flag are captured into an internal exc register → FINAL.
  - FINAL: load_final=1. exc_sel is driven from the exc register → DONE.
  - DONE: ready=1. exc_sel is held. ack_op=1 → IDLE; otherwise stay.
- exc_sel is 00 in all states except FINAL and DONE.
- If both overflow_flag and underflow_flag are set, overflow wins (exc_sel=01).
- sel_exp_inc is 0 in every state except EXP_UPD.
- Latency: beg_op sampled at edge k.
  - ready first high in cycle k+6+RND_LAT when exp_na=0.
  - ready first high in cycle k+7+RND_LAT when exp_na=1.
- beg_op while busy is ignored and never queued.
- ack_op and beg_op both high in DONE: go to IDLE; beg_op is not captured and must be held or re-asserted in IDLE.
- ack_op outside DONE is ignored.
- busy=1 in ROUND through DONE inclusive.
- Counter is 4 bits. An RND_LAT value above 15 is a parameter error, checked at elaboration.

Decomposition:
- Shared package fpu_ctrl_pkg:
  - State encodings, 4-bit binary: IDLE=0, ROUND=1, RWAIT=2, NORM=3, NA_CHK=4, EXP_UPD=5, FLAGS=6, FINAL=7, DONE=8.
  - exc_sel codes EXC_NONE, EXC_OVF, EXC_UNF.
- One sub-module, lat_counter: 4-bit loadable down-counter with load, dec and a zero/one flag, reused by other phase controllers.

Test Plan:
- Reset mid-op: assert rst=0 while in EXP_UPD → next cycle state IDLE and all outputs 0; a fresh beg_op then completes normally.
- Basic op: RND_LAT=1, beg_op pulse at edge 0, exp_na=0, no flags → load_rnd@1, load_norm@3, load_flags@5, load_final@6, ready@7, exc_sel=00, load_exp never asserted.
- Exponent update: same stimulus with exp_na=1 → load_exp and sel_exp_inc both high @5, ready@8.
- Exceptions:
  - overflow_flag=1 and underflow_flag=1 at FLAGS → exc_sel=01 in FINAL and DONE.
  - underflow_flag only → exc_sel=10.
- Handshake: hold ack_op=0 for 10 cycles in DONE → ready held and exc_sel stable. Extra beg_op pulses while busy → ignored.
- ack_op and beg_op high together in DONE → IDLE, with no ROUND the following cycle.
- RND_LAT=0 build → ROUND goes directly to NORM; ready@6.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// Shared types for the FPU phase controllers: state encodings, exception
// select codes and the flag-to-select priority encoder.
package fpu_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ROUND   = 4'd1,
    ST_RWAIT   = 4'd2,
    ST_NORM    = 4'd3,
    ST_NA_CHK  = 4'd4,
    ST_EXP_UPD = 4'd5,
    ST_FLAGS   = 4'd6,
    ST_FINAL   = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_OVF  = 2'b01,
    EXC_UNF  = 2'b10
  } exc_e;

  // Overflow takes priority when both exponent flags are raised together.
  function automatic exc_e exc_encode(input logic ovf, input logic unf);
    if (ovf) begin
      return EXC_OVF;
    end else if (unf) begin
      return EXC_UNF;
    end
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/fpu_final_phase_ctrl_lat_counter.sv
// Loadable down-counter with zero/one flags, shared by the FPU phase
// controllers to time fixed-latency wait states.
module lat_counter
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero_c,
  output logic         is_one_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_c = (cnt_q == '0);
  assign is_one_c  = (cnt_q == W'(1));

endmodule

// File: rtl/fpu_final_phase_ctrl.sv
// Sequencer for the multiplier's final phases: round, post-round normalize,
// optional exponent increment, exception capture and result packing.
module fpu_final_phase_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned W_Sgf   = 23,
  parameter int unsigned RND_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beg_op,
  input  logic       ack_op,
  input  logic       exp_na,
  input  logic       overflow_flag,
  input  logic       underflow_flag,
  output logic       load_rnd,
  output logic       load_norm,
  output logic       load_exp,
  output logic       sel_exp_inc,
  output logic       load_flags,
  output logic       load_final,
  output logic [1:0] exc_sel,
  output logic       busy,
  output logic       ready
);

  if (RND_LAT > CNT_MAX) begin : g_bad_rnd_lat
    $error("RND_LAT must be in 0..15");
  end

  if ((W_Sgf != 23) && (W_Sgf != 52)) begin : g_bad_w_sgf
    $error("W_Sgf must be 23 or 52");
  end

  state_e state_q, state_d;
  exc_e   exc_q, exc_d;
  exc_e   exc_sel_q, exc_sel_d;

  logic load_rnd_q, load_rnd_d;
  logic load_norm_q, load_norm_d;
  logic load_exp_q, load_exp_d;
  logic sel_exp_inc_q, sel_exp_inc_d;
  logic load_flags_q, load_flags_d;
  logic load_final_q, load_final_d;
  logic busy_q, busy_d;
  logic ready_q, ready_d;

  logic cnt_load_c;
  logic cnt_dec_c;
  logic cnt_zero_c;
  logic cnt_one_c;

  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load_c),
    .load_val  (CNT_W'(RND_LAT)),
    .dec       (cnt_dec_c),
    .is_zero_c (cnt_zero_c),
    .is_one_c  (cnt_one_c)
  );

  // Next state, then outputs decoded from next state so the registered
  // strobes line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    exc_d      = exc_q;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beg_op) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        cnt_load_c = 1'b1;
        state_d    = (RND_LAT == 0) ? ST_NORM : ST_RWAIT;
      end
      ST_RWAIT: begin
        cnt_dec_c = 1'b1;
        // Zero is unreachable here; treated as an exit so the wait can never stick.
        if (cnt_one_c || cnt_zero_c) state_d = ST_NORM;
      end
      ST_NORM:    state_d = ST_NA_CHK;
      ST_NA_CHK:  state_d = exp_na ? ST_EXP_UPD : ST_FLAGS;
      ST_EXP_UPD: state_d = ST_FLAGS;
      ST_FLAGS: begin
        exc_d   = exc_encode(overflow_flag, underflow_flag);
        state_d = ST_FINAL;
      end
      ST_FINAL:   state_d = ST_DONE;
      ST_DONE: begin
        if (ack_op) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase

    load_rnd_d    = (state_d == ST_ROUND);
    load_norm_d   = (state_d == ST_NORM);
    load_exp_d    = (state_d == ST_EXP_UPD);
    sel_exp_inc_d = (state_d == ST_EXP_UPD);
    load_flags_d  = (state_d == ST_FLAGS);
    load_final_d  = (state_d == ST_FINAL);
    busy_d        = (state_d != ST_IDLE);
    ready_d       = (state_d == ST_DONE);
    exc_sel_d     = ((state_d == ST_FINAL) || (state_d == ST_DONE)) ? exc_d : EXC_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      exc_q         <= EXC_NONE;
      exc_sel_q     <= EXC_NONE;
      load_rnd_q    <= 1'b0;
      load_norm_q   <= 1'b0;
      load_exp_q    <= 1'b0;
      sel_exp_inc_q <= 1'b0;
      load_flags_q  <= 1'b0;
      load_final_q  <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      exc_q         <= exc_d;
      exc_sel_q     <= exc_sel_d;
      load_rnd_q    <= load_rnd_d;
      load_norm_q   <= load_norm_d;
      load_exp_q    <= load_exp_d;
      sel_exp_inc_q <= sel_exp_inc_d;
      load_flags_q  <= load_flags_d;
      load_final_q  <= load_final_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
    end
  end

  assign load_rnd    = load_rnd_q;
  assign load_norm   = load_norm_q;
  assign load_exp    = load_exp_q;
  assign sel_exp_inc = sel_exp_inc_q;
  assign load_flags  = load_flags_q;
  assign load_final  = load_final_q;
  assign exc_sel     = exc_sel_q;
  assign busy        = busy_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_fpu_final_phase_ctrl.sv
// Directed bench: one controller with RND_LAT=1 and one with RND_LAT=0 run
// side by side and are compared cycle by cycle against a hand-built timeline.
module tb_fpu_final_phase_ctrl;

  logic clk = 1'b0;
  logic rst, beg_op, ack_op, exp_na, ovf, unf;

  logic       a_rnd, a_norm, a_exp, a_inc, a_flags, a_final, a_busy, a_ready;
  logic [1:0] a_exc;
  logic       b_rnd, b_norm, b_exp, b_inc, b_flags, b_final, b_busy, b_ready;
  logic [1:0] b_exc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fpu_final_phase_ctrl #(.W_Sgf(23), .RND_LAT(1)) dut (
    .clk(clk), .rst(rst), .beg_op(beg_op), .ack_op(ack_op), .exp_na(exp_na),
    .overflow_flag(ovf), .underflow_flag(unf),
    .load_rnd(a_rnd), .load_norm(a_norm), .load_exp(a_exp), .sel_exp_inc(a_inc),
    .load_flags(a_flags), .load_final(a_final), .exc_sel(a_exc),
    .busy(a_busy), .ready(a_ready)
  );

  fpu_final_phase_ctrl #(.W_Sgf(52), .RND_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .beg_op(beg_op), .ack_op(ack_op), .exp_na(exp_na),
    .overflow_flag(ovf), .underflow_flag(unf),
    .load_rnd(b_rnd), .load_norm(b_norm), .load_exp(b_exp), .sel_exp_inc(b_inc),
    .load_flags(b_flags), .load_final(b_final), .exc_sel(b_exc),
    .busy(b_busy), .ready(b_ready)
  );

  // Output vector: {rnd, norm, exp, inc, flags, final, exc[1:0], busy, ready}
  function automatic logic [9:0] vec_a();
    return {a_rnd, a_norm, a_exp, a_inc, a_flags, a_final, a_exc, a_busy, a_ready};
  endfunction

  function automatic logic [9:0] vec_b();
    return {b_rnd, b_norm, b_exp, b_inc, b_flags, b_final, b_exc, b_busy, b_ready};
  endfunction

  // Expected outputs c cycles after the edge that sampled beg_op.
  function automatic logic [9:0] exp_vec(int c, int lat, bit na, logic [1:0] exc);
    int n;
    int f;
    n = 2 + lat;
    f = na ? n + 3 : n + 2;
    if (c == 1)                return 10'b10_0000_00_10;
    if (c < n)                 return 10'b00_0000_00_10;
    if (c == n)                return 10'b01_0000_00_10;
    if (c == n + 1)            return 10'b00_0000_00_10;
    if (na && (c == n + 2))    return 10'b00_1100_00_10;
    if (c == f)                return 10'b00_0010_00_10;
    if (c == f + 1)            return {6'b00_0001, exc, 2'b10};
    return {6'b00_0000, exc, 2'b11};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; noise adds stray beg_op/ack_op pulses while busy.
  task automatic run_op(input string name, input bit na, input bit o, input bit u,
                        input logic [1:0] exc, input int last_c, input bit noise,
                        input bit beg_with_ack);
    exp_na = na; ovf = o; unf = u;
    beg_op = 1'b1;
    tick();
    beg_op = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      chk($sformatf("%s_l1_c%0d", name, c), vec_a(), exp_vec(c, 1, na, exc));
      chk($sformatf("%s_l0_c%0d", name, c), vec_b(), exp_vec(c, 0, na, exc));
      if (noise) begin
        beg_op = (c == 3) || (c == 5);
        ack_op = (c == 2);
      end
      tick();
    end
    beg_op = beg_with_ack;
    ack_op = 1'b1;
    tick();
    ack_op = 1'b0;
    beg_op = 1'b0;
    chk($sformatf("%s_ack_l1", name), vec_a(), 10'd0);
    chk($sformatf("%s_ack_l0", name), vec_b(), 10'd0);
    tick();
    chk($sformatf("%s_post_l1", name), vec_a(), 10'd0);
    chk($sformatf("%s_post_l0", name), vec_b(), 10'd0);
  endtask

  initial begin
    rst = 1'b0; beg_op = 1'b0; ack_op = 1'b0; exp_na = 1'b0; ovf = 1'b0; unf = 1'b0;
    tick();
    tick();
    chk("reset_l1", vec_a(), 10'd0);
    chk("reset_l0", vec_b(), 10'd0);
    rst = 1'b1;
    tick();
    chk("idle_l1", vec_a(), 10'd0);

    run_op("basic",  1'b0, 1'b0, 1'b0, 2'b00, 9,  1'b0, 1'b0);
    run_op("expinc", 1'b1, 1'b0, 1'b0, 2'b00, 9,  1'b0, 1'b0);
    run_op("ovfunf", 1'b0, 1'b1, 1'b1, 2'b01, 9,  1'b0, 1'b0);
    run_op("unf",    1'b1, 1'b0, 1'b1, 2'b10, 18, 1'b1, 1'b0);
    run_op("ackbeg", 1'b0, 1'b0, 1'b0, 2'b00, 9,  1'b0, 1'b1);

    // Reset while the RND_LAT=1 controller sits in EXP_UPD (cycle 5).
    exp_na = 1'b1; ovf = 1'b1; unf = 1'b0;
    beg_op = 1'b1;
    tick();
    beg_op = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("pre_rst_exp_upd", vec_a(), exp_vec(5, 1, 1'b1, 2'b01));
    rst = 1'b0;
    tick();
    chk("midrst_l1", vec_a(), 10'd0);
    chk("midrst_l0", vec_b(), 10'd0);
    rst = 1'b1;
    tick();
    chk("midrst_idle_l1", vec_a(), 10'd0);
    run_op("fresh", 1'b0, 1'b0, 1'b0, 2'b00, 9, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
